// File: rtl/jk_counter_ctrl.sv
// jk_counter_ctrl: excitation stage for a bank of WIDTH JK flip-flops that
// together form a modulo-MODULUS up/down counter.
//
// Each cycle it works out the next-state target N and emits the per-bit J/K
// drive that moves the external flops from q to N on the next edge. A shadow
// copy of the count is kept here by applying the JK rule to those same drives.
// External flops wired to j_out/k_out, on the same clk and clear_n, track q
// exactly.
//
// Optional feature: define JK_WRAP_CNT_EN to add the wrap_cnt output.
//
// Ports:
//   clk       in   rising-edge clock
//   clear_n   in   synchronous active-low reset, sampled on posedge clk
//   en        in   count enable
//   up_dn     in   1 = count up, 0 = count down
//   load      in   load request; takes priority over en
//   load_val  in   value to load (WIDTH bits)
//   q         out  current count (shadow state register)
//   j_out     out  J drive for the next edge (combinational)
//   k_out     out  K drive for the next edge (combinational)
//   tc        out  terminal count (combinational)
//   load_err  out  registered 1-cycle pulse: the last load_val was out of range
//   wrap_cnt  out  saturating count of wraps (only with JK_WRAP_CNT_EN)

module jk_counter_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             tc,
`ifdef JK_WRAP_CNT_EN
  output logic [7:0]       wrap_cnt,
`endif
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] tgt;
  logic             load_in_range;

  // Next-state target, excitation, terminal count and shadow update.
  always_comb begin
    tgt           = q_q;
    load_err_d    = 1'b0;
    j_out         = '0;
    k_out         = '0;
    tc            = 1'b0;
    q_d           = q_q;
    // Compare at 32 bits so MODULUS = 2^WIDTH is representable.
    load_in_range = (32'(load_val) < MODULUS);

    if (load) begin
      if (load_in_range) begin
        tgt = load_val;
      end else begin
        tgt        = MAX_VAL;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        tgt = (q_q == MAX_VAL) ? ZERO : q_q + ONE;
      end else begin
        tgt = (q_q == ZERO) ? MAX_VAL : q_q - ONE;
      end
    end

    if (!clear_n) begin
      // Drive the external flops to zero on the same edge.
      j_out      = '0;
      k_out      = '1;
      load_err_d = 1'b0;
      q_d        = '0;
    end else begin
      // Set only bits rising, reset only bits falling; never toggle-encode.
      j_out = tgt & ~q_q;
      k_out = ~tgt & q_q;
      q_d   = (j_out & ~q_q) | (~k_out & q_q);
      tc    = en & ~load & ((up_dn & (q_q == MAX_VAL)) | (~up_dn & (q_q == ZERO)));
    end
  end

  // Shadow count and load error pulse.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      q_q        <= '0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign load_err = load_err_q;

`ifdef JK_WRAP_CNT_EN
  logic [7:0] wrap_cnt_q, wrap_cnt_d;

  // Saturating wrap counter; tc already excludes reset cycles.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (tc && (wrap_cnt_q != 8'hFF)) begin
      wrap_cnt_d = wrap_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      wrap_cnt_q <= 8'd0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Directed bench for jk_counter_ctrl (WIDTH=4, MODULUS=10). A bank of
// behavioural JK flops driven from j_out/k_out is compared against q.

module tb_jk_counter_ctrl;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned MODULUS = 10;

  logic             clk;
  logic             clear_n;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             tc;
  logic             load_err;
`ifdef JK_WRAP_CNT_EN
  logic [7:0]       wrap_cnt;
`endif

  int n_vec;
  int n_err;
  int cnt;

  logic [WIDTH-1:0] ext_q;

  jk_counter_ctrl #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .j_out    (j_out),
    .k_out    (k_out),
    .tc       (tc),
`ifdef JK_WRAP_CNT_EN
    .wrap_cnt (wrap_cnt),
`endif
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent JK flop bank with full JK semantics, including toggle.
  always @(posedge clk) begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({j_out[i], k_out[i]})
        2'b00:   ext_q[i] <= ext_q[i];
        2'b01:   ext_q[i] <= 1'b0;
        2'b10:   ext_q[i] <= 1'b1;
        default: ext_q[i] <= ~ext_q[i];
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge, then check the structural invariants.
  task automatic step();
    check("no_toggle", 32'(j_out & k_out), 32'd0);
    @(posedge clk);
    #1;
    check("ext_track", 32'(ext_q), 32'(q));
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    clear_n  = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = '0;
    #1;

    // 1. Reset for two edges
    check("rst_j", 32'(j_out), 32'h0);
    check("rst_k", 32'(k_out), 32'hF);
    check("rst_tc", 32'(tc), 32'd0);
    @(posedge clk); #1;
    check("rst_j2", 32'(j_out), 32'h0);
    check("rst_k2", 32'(k_out), 32'hF);
    @(posedge clk); #1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_lerr", 32'(load_err), 32'd0);
    check("rst_ext", 32'(ext_q), 32'd0);
    clear_n = 1'b1;
    #1;
    check("idle_tc", 32'(tc), 32'd0);
    step();
    check("idle_q", 32'(q), 32'd0);

    // 2. Count up with wrap
    en = 1'b1; up_dn = 1'b1; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("up_tc", 32'(tc), (cnt == 9) ? 32'd1 : 32'd0);
      if (cnt == 7) begin
        check("up_j_7to8", 32'(j_out), 32'h8);
        check("up_k_7to8", 32'(k_out), 32'h7);
      end
      step();
      cnt = (cnt + 1) % 10;
      check("up_q", 32'(q), 32'(cnt));
    end
    check("up_end", 32'(q), 32'd2);

    // up_dn changes take effect immediately
    up_dn = 1'b0; step(); check("dir_dn", 32'(q), 32'd1);
    up_dn = 1'b1; step(); check("dir_up", 32'(q), 32'd2);

    // 3. Count down from 0 with wrap
    en = 1'b0; load = 1'b1; load_val = 4'd0;
    step(); check("ld0_q", 32'(q), 32'd0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    #1; check("dn_tc0", 32'(tc), 32'd1);
    step(); check("dn_q9", 32'(q), 32'd9);
    check("dn_tc9", 32'(tc), 32'd0);
    step(); check("dn_q8", 32'(q), 32'd8);
    step(); check("dn_q7", 32'(q), 32'd7);

    // 4. Loads: in range, out of range with en, boundary
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    step(); check("ld9_q", 32'(q), 32'd9);
    check("ld9_err", 32'(load_err), 32'd0);
    en = 1'b1; up_dn = 1'b1; load_val = 4'd12;
    #1; check("ld_tc", 32'(tc), 32'd0);
    step(); check("ld12_q", 32'(q), 32'd9);
    check("ld12_err", 32'(load_err), 32'd1);
    load_val = 4'd5;
    step(); check("ld5_q", 32'(q), 32'd5);
    check("ld5_err", 32'(load_err), 32'd0);
    load_val = 4'd10;
    step(); check("ld10_q", 32'(q), 32'd9);
    check("ld10_err", 32'(load_err), 32'd1);
    load = 1'b0; en = 1'b0;
    step(); check("hold_q", 32'(q), 32'd9);
    check("hold_err", 32'(load_err), 32'd0);

    // 5. Reset mid-count wins over en
    load = 1'b1; load_val = 4'd6;
    step(); check("ld6_q", 32'(q), 32'd6);
    load = 1'b0; en = 1'b1; up_dn = 1'b1; clear_n = 1'b0;
    #1; check("mrst_tc", 32'(tc), 32'd0);
    step(); check("mrst_q", 32'(q), 32'd0);
    clear_n = 1'b1;
    step(); check("resume_q1", 32'(q), 32'd1);
    step(); check("resume_q2", 32'(q), 32'd2);

`ifdef JK_WRAP_CNT_EN
    // 6. Wrap counter saturation and clear
    clear_n = 1'b0; step(); clear_n = 1'b1;
    check("wc_rst", 32'(wrap_cnt), 32'd0);
    en = 1'b1; up_dn = 1'b1; cnt = 0;
    for (int w = 0; w < 300; w++) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
      end
      if (w == 9) check("wc_10", 32'(wrap_cnt), 32'd10);
    end
    check("wc_sat", 32'(wrap_cnt), 32'd255);
    check("wc_ext", 32'(ext_q), 32'(q));
    clear_n = 1'b0; step(); clear_n = 1'b1;
    check("wc_clr", 32'(wrap_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
Upstream excitation stage for a bank of WIDTH JK flip-flops that together form a modulo-MODULUS up/down counter.
- Each cycle it computes per-bit J/K drive vectors for the next clock edge.
- It keeps an internal shadow state register updated by the JK rule: q_next = (j & ~q) | (~k & q).
- It reports terminal count and load errors.
- Downstream JK flops wired to j_out/k_out with the same clk/clear_n track q exactly.

Parameters:
WIDTH, 4, counter/bit-bank width
MODULUS, 10, count modulus; legal range 2..2^WIDTH

Ports:
clk  input  1  rising-edge clock
clear_n  input  1  synchronous active-low reset (sampled on posedge clk only)
en  input  1  count enable
up_dn  input  1  1 = count up, 0 = count down
load  input  1  load request; priority over en
load_val  input  WIDTH  value to load
q  output  WIDTH  current count (shadow state register)
j_out  output  WIDTH  J drive for the next edge
k_out  output  WIDTH  K drive for the next edge
tc  output  1  terminal count (combinational)
load_err  output  1  registered 1-cycle pulse: load_val was out of range

Behaviour:
- Reset
  - clear_n low at posedge clk: q=0, load_err=0.
  - While clear_n is low: j_out=0, k_out=all ones, so external flops clear on the same edge.
  - There is no asynchronous path; clear_n falling between edges has no effect until the next posedge.
- Next-state target N, combinational, in priority order:
  1. load=1: N = load_val if load_val < MODULUS, else N = MODULUS-1 and load_err=1 on the next cycle.
  2. en=1, up_dn=1: N = (q==MODULUS-1) ? 0 : q+1.
  3. en=1, up_dn=0: N = (q==0) ? MODULUS-1 : q-1.
  4. Otherwise: N = q.
- Excitation, per bit i:
  - q[i]=0, N[i]=1: j=1, k=0.
  - q[i]=1, N[i]=0: j=0, k=1.
  - Bit unchanged: j=0, k=0 (hold).
  - Toggle encoding (j=k=1) is never emitted; j&k is always 0.
- Update: q <= (j_out & ~q) | (~k_out & q) on every posedge while clear_n is high. Latency from command to q is 1 cycle.
- tc = clear_n & en & ~load & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)).
- load_err: registered, high exactly 1 cycle after an out-of-range load, otherwise 0.
- Boundaries
  - Wrap in both directions as listed above.
  - load asserted together with en: load wins and tc=0.
  - up_dn may change every cycle; it takes effect immediately.
  - Reset asserted mid-count: q=0 on that edge; en/load in that cycle are ignored.
- Arithmetic is WIDTH bits; when MODULUS = 2^WIDTH the wraps are natural overflow/underflow.

Optional Feature:
Macro JK_WRAP_CNT_EN.
- Defined:
  - Adds output wrap_cnt [7:0].
  - Reset value 0.
  - Increments on every edge where tc=1 (a wrap occurs).
  - Saturates at 255.
  - Cleared only by clear_n.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=4, MODULUS=10):
1. clear_n=0 for 2 edges, then 1; en=0 -> q=0, load_err=0; while reset is low, j_out=0000 and k_out=1111.
2. en=1, up_dn=1 for 12 cycles from q=0 -> q steps 1..9, 0, 1, 2; tc=1 only while q=9; at q=7->8, j_out=1000 and k_out=0111.
3. en=1, up_dn=0 from q=0 -> next q=9 with tc=1 during q=0; next q values 8, 7; check j_out & k_out == 0 every cycle.
4. load=1, load_val=12, en=1 -> q=9 next cycle; load_err=1 for exactly 1 cycle; tc=0 in the load cycle. load_val=5 -> q=5, load_err=0.
5. Counting up at q=6, clear_n=0 for 1 edge with en=1 -> q=0 (not 7); counting resumes 1, 2 after release.
6. With JK_WRAP_CNT_EN: 300 up-wraps -> wrap_cnt saturates at 255; clear_n -> 0. A parallel bench of external JK flops driven by j_out/k_out must match q every cycle.
